branch_resolver: RTL and testbench

- Update-side counterpart of the branch predictor. It tracks every fetch-time prediction in an in-order queue and compares each one against the outcome resolved in EX.
- It drives the predictor's update port (upd_en, upd_addr, upd_jumpinst, upd_jump, upd_predfail, upd_target).
- On a misprediction it issues a fetch redirect and discards wrong-path queue entries.
- Sits between IF (push side) and EX (resolve side).

---
 rtl/branch_resolver_if.sv | 47 ++++
 rtl/branch_resolver.sv | 118 +++++++++++
 tb/tb_branch_resolver.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolver_if.sv
// Signal bundle between IF, EX, the branch predictor update port and the branch resolver.
// The resolver uses the slave side; whatever drives IF/EX stimulus uses the master side.
interface branch_resolver_if;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_pc;
    logic        fetch_pred_jump;
    logic [31:0] fetch_pred_target;

    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_is_branch;
    logic        ex_taken;
    logic [31:0] ex_target;

    logic        upd_en;
    logic [31:0] upd_addr;
    logic        upd_jumpinst;
    logic        upd_jump;
    logic        upd_predfail;
    logic [31:0] upd_target;

    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic        seq_error;
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;

    modport slave (
        input  fetch_valid, fetch_pc, fetch_pred_jump, fetch_pred_target,
        input  ex_valid, ex_pc, ex_is_branch, ex_taken, ex_target,
        output fetch_ready,
        output upd_en, upd_addr, upd_jumpinst, upd_jump, upd_predfail, upd_target,
        output redirect_valid, redirect_pc,
        output seq_error, branch_cnt, mispred_cnt
    );

    modport master (
        output fetch_valid, fetch_pc, fetch_pred_jump, fetch_pred_target,
        output ex_valid, ex_pc, ex_is_branch, ex_taken, ex_target,
        input  fetch_ready,
        input  upd_en, upd_addr, upd_jumpinst, upd_jump, upd_predfail, upd_target,
        input  redirect_valid, redirect_pc,
        input  seq_error, branch_cnt, mispred_cnt
    );
endinterface

// File: rtl/branch_resolver.sv
// In-order queue of fetch-time predictions, checked against EX outcomes; drives
// predictor updates, fetch redirects on mispredict, and resolve statistics.
module branch_resolver #(
    parameter int QDEPTH = 8,
    parameter int QAW    = 3
) (
    input  logic clk,
    input  logic reset,
    branch_resolver_if.slave bus
);
    localparam logic [QAW:0]   FULL_CNT = (QAW+1)'(QDEPTH);
    localparam logic [QAW-1:0] PTR_ONE  = QAW'(1);

    logic [31:0]    q_pc [QDEPTH];
    logic           q_pj [QDEPTH];
    logic [31:0]    q_pt [QDEPTH];

    logic [QAW-1:0] head, tail;
    logic [QAW:0]   count;

    logic [31:0]    h_pc, h_pt;
    logic           h_pj;
    logic           empty, full, resolve, pc_match, taken_act, mispred, upd_fire, push;

    logic           upd_en_q, upd_jumpinst_q, upd_jump_q, upd_predfail_q;
    logic [31:0]    upd_addr_q, upd_target_q;
    logic           redirect_valid_q;
    logic [31:0]    redirect_pc_q;
    logic           seq_error_q;
    logic [31:0]    branch_cnt_q, mispred_cnt_q;

    always_comb begin
        empty     = (count == '0);
        full      = (count == FULL_CNT);
        h_pc      = q_pc[head];
        h_pj      = q_pj[head];
        h_pt      = q_pt[head];
        // While a redirect is out, anything arriving from EX is wrong-path.
        resolve   = bus.ex_valid & ~redirect_valid_q & ~empty;
        pc_match  = (bus.ex_pc == h_pc);
        taken_act = bus.ex_is_branch & bus.ex_taken;
        mispred   = resolve & pc_match &
                    ((taken_act != h_pj) | (taken_act & h_pj & (bus.ex_target != h_pt)));
        upd_fire  = resolve & pc_match & (bus.ex_is_branch | h_pj);
        push      = bus.fetch_valid & ~full & ~mispred & ~redirect_valid_q;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[tail] <= bus.fetch_pc;
            q_pj[tail] <= bus.fetch_pred_jump;
            q_pt[tail] <= bus.fetch_pred_target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (mispred) begin
            head  <= tail;
            count <= '0;
        end else begin
            if (push)    tail <= tail + PTR_ONE;
            if (resolve) head <= head + PTR_ONE;
            case ({push, resolve})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            upd_en_q         <= 1'b0;
            upd_addr_q       <= '0;
            upd_jumpinst_q   <= 1'b0;
            upd_jump_q       <= 1'b0;
            upd_predfail_q   <= 1'b0;
            upd_target_q     <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            seq_error_q      <= 1'b0;
            branch_cnt_q     <= '0;
            mispred_cnt_q    <= '0;
        end else begin
            upd_en_q         <= upd_fire;
            upd_addr_q       <= upd_fire ? bus.ex_pc : '0;
            upd_jumpinst_q   <= upd_fire & bus.ex_is_branch;
            upd_jump_q       <= upd_fire & taken_act;
            upd_predfail_q   <= upd_fire & mispred;
            upd_target_q     <= upd_fire ? bus.ex_target : '0;
            redirect_valid_q <= mispred;
            redirect_pc_q    <= mispred ? (taken_act ? bus.ex_target : bus.ex_pc + 32'd4) : '0;
            if ((bus.ex_valid & ~redirect_valid_q & empty) | (resolve & ~pc_match))
                seq_error_q <= 1'b1;
            if (resolve & pc_match & bus.ex_is_branch & (branch_cnt_q != '1))
                branch_cnt_q <= branch_cnt_q + 32'd1;
            if (mispred & (mispred_cnt_q != '1))
                mispred_cnt_q <= mispred_cnt_q + 32'd1;
        end
    end

    assign bus.fetch_ready    = ~full;
    assign bus.upd_en         = upd_en_q;
    assign bus.upd_addr       = upd_addr_q;
    assign bus.upd_jumpinst   = upd_jumpinst_q;
    assign bus.upd_jump       = upd_jump_q;
    assign bus.upd_predfail   = upd_predfail_q;
    assign bus.upd_target     = upd_target_q;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.seq_error      = seq_error_q;
    assign bus.branch_cnt     = branch_cnt_q;
    assign bus.mispred_cnt    = mispred_cnt_q;
endmodule

// File: tb/tb_branch_resolver.sv
// Directed stimulus for branch_resolver; expected update/redirect records go into a
// scoreboard queue and a monitor compares them whenever the resolver presents an output.
module tb_branch_resolver;
    logic clk;
    logic reset;
    branch_resolver_if bi ();

    branch_resolver #(.QDEPTH(8), .QAW(3)) dut (.clk(clk), .reset(reset), .bus(bi.slave));

    typedef struct packed {
        logic        en;
        logic [31:0] addr;
        logic        ji;
        logic        j;
        logic        pf;
        logic [31:0] tgt;
        logic        rv;
        logic [31:0] rpc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   mon_stop = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(logic en, logic [31:0] addr, logic ji, logic j, logic pf,
                                logic [31:0] tgt, logic rv, logic [31:0] rpc);
        exp_t e;
        e = '{en, addr, ji, j, pf, tgt, rv, rpc};
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        bi.fetch_valid       = 1'b0;
        bi.fetch_pc          = '0;
        bi.fetch_pred_jump   = 1'b0;
        bi.fetch_pred_target = '0;
        bi.ex_valid          = 1'b0;
        bi.ex_pc             = '0;
        bi.ex_is_branch      = 1'b0;
        bi.ex_taken          = 1'b0;
        bi.ex_target         = '0;
    endtask

    task automatic set_push(input logic [31:0] pc, input logic pj, input logic [31:0] pt);
        bi.fetch_valid       = 1'b1;
        bi.fetch_pc          = pc;
        bi.fetch_pred_jump   = pj;
        bi.fetch_pred_target = pt;
    endtask

    task automatic set_res(input logic [31:0] pc, input logic br, input logic tk, input logic [31:0] tgt);
        bi.ex_valid     = 1'b1;
        bi.ex_pc        = pc;
        bi.ex_is_branch = br;
        bi.ex_taken     = tk;
        bi.ex_target    = tgt;
    endtask

    task automatic push_one(input logic [31:0] pc, input logic pj, input logic [31:0] pt);
        set_push(pc, pj, pt);
        tick();
        clr();
    endtask

    task automatic res_one(input logic [31:0] pc, input logic br, input logic tk, input logic [31:0] tgt);
        set_res(pc, br, tk, tgt);
        tick();
        clr();
    endtask

    // Monitor: compares every presented update/redirect against the scoreboard head,
    // and insists all update/redirect outputs are zero when nothing is presented.
    initial begin
        exp_t got, e;
        while (!mon_stop) begin
            @(negedge clk);
            got = '{bi.upd_en, bi.upd_addr, bi.upd_jumpinst, bi.upd_jump, bi.upd_predfail,
                    bi.upd_target, bi.redirect_valid, bi.redirect_pc};
            n_checks++;
            if (bi.upd_en || bi.redirect_valid) begin
                if (sb.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_output: got %h want none", got);
                end else begin
                    e = sb.pop_front();
                    if (got !== e) begin
                        n_errors++;
                        $display("FAIL upd_redirect: got %h want %h", got, e);
                    end
                end
            end else if (got !== '0) begin
                n_errors++;
                $display("FAIL idle_outputs: got %h want 0", got);
            end
        end
    end

    initial begin
        clr();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        chk("rst_fetch_ready", 32'(bi.fetch_ready), 32'd1);
        chk("rst_seq_error",   32'(bi.seq_error), 32'd0);
        chk("rst_branch_cnt",  bi.branch_cnt, 32'd0);
        chk("rst_mispred_cnt", bi.mispred_cnt, 32'd0);

        // Correctly predicted taken branch
        push_one(32'h100, 1'b1, 32'h200);
        sb.push_back(mk(1, 32'h100, 1, 1, 0, 32'h200, 0, 32'h0));
        res_one(32'h100, 1'b1, 1'b1, 32'h200);
        chk("t1_branch_cnt", bi.branch_cnt, 32'd1);
        chk("t1_mispred_cnt", bi.mispred_cnt, 32'd0);

        // Direction mispredict; push in detection cycle and during redirect are dropped,
        // and EX activity during redirect is ignored
        push_one(32'h100, 1'b0, 32'h0);
        push_one(32'h104, 1'b0, 32'h0);
        push_one(32'h108, 1'b0, 32'h0);
        sb.push_back(mk(1, 32'h100, 1, 1, 1, 32'h400, 1, 32'h400));
        set_push(32'h10C, 1'b0, 32'h0);
        set_res(32'h100, 1'b1, 1'b1, 32'h400);
        tick();
        clr();
        set_push(32'h500, 1'b0, 32'h0);
        set_res(32'h104, 1'b1, 1'b0, 32'h0);
        chk("t2_ready_in_redirect", 32'(bi.fetch_ready), 32'd1);
        tick();
        clr();
        chk("t2_mispred_cnt", bi.mispred_cnt, 32'd1);
        chk("t2_seq_error", 32'(bi.seq_error), 32'd0);

        // Target mismatch (also proves the queue was empty after the flush)
        push_one(32'h20, 1'b1, 32'h80);
        sb.push_back(mk(1, 32'h20, 1, 1, 1, 32'h90, 1, 32'h90));
        res_one(32'h20, 1'b1, 1'b1, 32'h90);
        tick();
        chk("t3_seq_error", 32'(bi.seq_error), 32'd0);

        // Non-branch predicted taken
        push_one(32'h40, 1'b1, 32'h60);
        sb.push_back(mk(1, 32'h40, 0, 0, 1, 32'h0, 1, 32'h44));
        res_one(32'h40, 1'b0, 1'b0, 32'h0);
        tick();

        // Non-branch predicted not-taken: no update at all
        push_one(32'h50, 1'b0, 32'h0);
        res_one(32'h50, 1'b0, 1'b0, 32'h0);

        // Fall-through redirect wraps at the top of the address space
        push_one(32'hFFFF_FFFC, 1'b1, 32'h1000);
        sb.push_back(mk(1, 32'hFFFF_FFFC, 1, 0, 1, 32'h0, 1, 32'h0));
        res_one(32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0);
        tick();
        chk("t3_branch_cnt", bi.branch_cnt, 32'd4);
        chk("t3_mispred_cnt", bi.mispred_cnt, 32'd4);

        // Fill, refuse while full, then stream pop+push across pointer wrap, then drain
        for (int i = 0; i < 8; i++) push_one(32'h1000 + 32'(4 * i), 1'b0, 32'h0);
        chk("t4_full_ready", 32'(bi.fetch_ready), 32'd0);
        set_push(32'hDEAD_0000, 1'b0, 32'h0);
        tick();
        clr();
        chk("t4_still_full", 32'(bi.fetch_ready), 32'd0);
        sb.push_back(mk(1, 32'h1000, 1, 0, 0, 32'h0, 0, 32'h0));
        res_one(32'h1000, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 20; i++) begin
            sb.push_back(mk(1, 32'h1000 + 32'(4 * (i + 1)), 1, 0, 0, 32'h0, 0, 32'h0));
            set_push(32'h1000 + 32'(4 * (8 + i)), 1'b0, 32'h0);
            set_res(32'h1000 + 32'(4 * (i + 1)), 1'b1, 1'b0, 32'h0);
            tick();
            clr();
        end
        for (int i = 21; i < 28; i++) begin
            sb.push_back(mk(1, 32'h1000 + 32'(4 * i), 1, 0, 0, 32'h0, 0, 32'h0));
            res_one(32'h1000 + 32'(4 * i), 1'b1, 1'b0, 32'h0);
        end
        chk("t4_seq_error", 32'(bi.seq_error), 32'd0);
        chk("t4_branch_cnt", bi.branch_cnt, 32'd32);
        chk("t4_ready_empty", 32'(bi.fetch_ready), 32'd1);

        // ex_valid while empty: sticky error
        res_one(32'h700, 1'b1, 1'b1, 32'h0);
        chk("t5_seq_error_empty", 32'(bi.seq_error), 32'd1);
        repeat (3) tick();
        chk("t5_seq_error_sticky", 32'(bi.seq_error), 32'd1);

        // Reset mid-stream
        for (int i = 0; i < 5; i++) push_one(32'h2000 + 32'(4 * i), 1'b0, 32'h0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_fetch_ready", 32'(bi.fetch_ready), 32'd1);
        chk("t6_seq_error", 32'(bi.seq_error), 32'd0);
        chk("t6_branch_cnt", bi.branch_cnt, 32'd0);
        chk("t6_mispred_cnt", bi.mispred_cnt, 32'd0);
        chk("t6_upd_en", 32'(bi.upd_en), 32'd0);

        // PC mismatch: error, no update, head still popped
        push_one(32'h100, 1'b0, 32'h0);
        push_one(32'h104, 1'b0, 32'h0);
        res_one(32'h300, 1'b1, 1'b1, 32'h999);
        chk("t7_seq_error", 32'(bi.seq_error), 32'd1);
        chk("t7_branch_cnt_mismatch", bi.branch_cnt, 32'd0);
        sb.push_back(mk(1, 32'h104, 1, 0, 0, 32'h0, 0, 32'h0));
        res_one(32'h104, 1'b1, 1'b0, 32'h0);
        chk("t7_branch_cnt", bi.branch_cnt, 32'd1);

        repeat (3) tick();
        mon_stop = 1'b1;
        repeat (2) tick();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
